// File: rtl/fp_normalize_round_pkg.sv
// rtl/fp_normalize_round_pkg.sv - shared definitions for the FP adder post-add stage
//
// Purpose: default field widths, IEEE-754 single constants and the
//          normalise/round FSM state encoding. The alignment and compare
//          stages import the same package.
// Ports:   none (package)

package fp_normalize_round_pkg;

  localparam int DEF_EXP_W = 8;    // exponent field width
  localparam int DEF_MAN_W = 23;   // stored fraction width, hidden bit at DEF_MAN_W
  localparam int BIAS      = 127;  // exponent bias of a single
  localparam int EXP_INF   = 255;  // biased exponent of infinity

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - round-to-nearest-even incrementer for a normalised mantissa
//
// Purpose: decides the RNE increment from G/R/S and the LSB, then adds it
//          through a ripple of full_adder cells. Purely combinational.
// Ports:
//   mant     in  MAN_W+1  mantissa including the hidden bit (no carry bit)
//   g, r, s  in  1        guard, round, sticky
//   rounded  out MAN_W+1  mantissa after the increment
//   carry    out 1        increment rippled out of the hidden bit position

module fp_round_rne #(
  parameter int MAN_W = 23
) (
  input  logic [MAN_W:0] mant,
  input  logic           g,
  input  logic           r,
  input  logic           s,
  output logic [MAN_W:0] rounded,
  output logic           carry
);

  logic             inc;
  logic [MAN_W+1:0] c;

  // Above half rounds up; an exact tie rounds up only when the LSB is odd.
  assign inc  = g & (r | s | mant[0]);
  assign c[0] = inc;

  // The increment enters as the carry-in of bit 0; the b operand is unused.
  for (genvar i = 0; i <= MAN_W; i++) begin : g_inc
    full_adder u_fa (
      .a    (mant[i]),
      .b    (1'b0),
      .cin  (c[i]),
      .s    (rounded[i]),
      .cout (c[i+1])
    );
  end

  assign carry = c[MAN_W+1];

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder cell used to build ripple chains
//
// Purpose: single-bit sum and carry; chained for the adder and the
//          rounding incrementer.
// Ports:
//   a, b  in  operand bits
//   cin   in  carry in
//   s     out sum bit
//   cout  out carry out

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/fp_normalize_round.sv
// rtl/fp_normalize_round.sv - iterative normalise, RNE round and IEEE-754 pack
//
// Purpose: post-add stage of the single-precision adder. Takes the raw
//          {Cout, Sum} mantissa, G/R/S and working exponent/sign, normalises
//          one shift per cycle, rounds to nearest even and packs the result.
// Ports:
//   clk       in  1              rising-edge clock
//   rst       in  1              synchronous active-high reset
//   start     in  1              accept operands (ignored while busy)
//   sign_in   in  1              result sign
//   exp_in    in  EXP_W          biased exponent, 1..254
//   mant_in   in  MAN_W+2        {carry-out, hidden, fraction}
//   grs_in    in  3              {guard, round, sticky}
//   busy      out 1              operation in flight
//   done      out 1              one-cycle completion pulse
//   result    out EXP_W+MAN_W+1  {sign, exp, frac}, held until next start
//   overflow  out 1              result saturated to infinity

module fp_normalize_round
  import fp_normalize_round_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sign_in,
  input  logic [EXP_W-1:0]       exp_in,
  input  logic [MAN_W+1:0]       mant_in,
  input  logic [2:0]             grs_in,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow
);

  state_t state, state_nx;

  // Working registers; the exponent carries one spare bit so a round-up
  // past 254 is seen as >= 255 instead of wrapping.
  logic [MAN_W+1:0] mant_q;
  logic             g_q, r_q, s_q;
  logic [EXP_W:0]   exp_q;
  logic             sign_q;

  logic is_zero;
  logic need_rsh;
  logic need_lsh;

  logic [MAN_W:0]     rounded;
  logic               carry;
  logic [EXP_W:0]     exp_rnd;
  logic               hidden;
  logic [MAN_W-1:0]   frac;
  logic               ovf_nx;
  logic [EXP_W+MAN_W:0] result_nx;

  assign is_zero  = (mant_q == '0) && !g_q && !r_q && !s_q;
  assign need_rsh = mant_q[MAN_W+1];
  // Left shifts stop at exponent 1: below that the value is a denormal.
  assign need_lsh = !mant_q[MAN_W] && (exp_q > (EXP_W+1)'(1));

  // In ROUND the carry bit is always clear, so only MAN_W+1 bits are rounded.
  fp_round_rne #(
    .MAN_W (MAN_W)
  ) u_round (
    .mant    (mant_q[MAN_W:0]),
    .g       (g_q),
    .r       (r_q),
    .s       (s_q),
    .rounded (rounded),
    .carry   (carry)
  );

  // Round-up overflow into bit MAN_W+1 is renormalised here: the mantissa is
  // then exactly 1.000..., so dropping rounded[0] loses nothing.
  always_comb begin
    exp_rnd   = exp_q + {{EXP_W{1'b0}}, carry};
    hidden    = carry | rounded[MAN_W];
    frac      = carry ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
    ovf_nx    = exp_rnd >= {1'b0, {EXP_W{1'b1}}};
    result_nx = '0;
    if (ovf_nx) begin
      result_nx = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      // Without the hidden bit the value sits at the exponent-1 floor and is
      // encoded as a denormal; a denormal rounding into the hidden bit keeps
      // exp_rnd==1, which is the correct encoding.
      result_nx = {sign_q, (hidden ? exp_rnd[EXP_W-1:0] : {EXP_W{1'b0}}), frac};
    end
  end

  // Next-state logic. A zero sum also passes through ROUND so every result,
  // zero included, completes k+3 cycles after the start edge.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_NORM;
        end
      end
      ST_NORM: begin
        if (is_zero) begin
          state_nx = ST_ROUND;
        end else if (need_rsh || need_lsh) begin
          state_nx = ST_NORM;
        end else begin
          state_nx = ST_ROUND;
        end
      end
      ST_ROUND: state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Datapath: operand latch, one shift per NORM cycle, result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mant_q   <= '0;
      g_q      <= 1'b0;
      r_q      <= 1'b0;
      s_q      <= 1'b0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            mant_q <= mant_in;
            g_q    <= grs_in[2];
            r_q    <= grs_in[1];
            s_q    <= grs_in[0];
            exp_q  <= {1'b0, exp_in};
            sign_q <= sign_in;
          end
        end
        ST_NORM: begin
          if (!is_zero) begin
            if (need_rsh) begin
              mant_q <= {1'b0, mant_q[MAN_W+1:1]};
              g_q    <= mant_q[0];
              r_q    <= g_q;
              s_q    <= r_q | s_q;
              exp_q  <= exp_q + (EXP_W+1)'(1);
            end else if (need_lsh) begin
              // Sticky stays put: it only records that something below R was non-zero.
              mant_q <= {mant_q[MAN_W:0], g_q};
              g_q    <= r_q;
              r_q    <= 1'b0;
              exp_q  <= exp_q - (EXP_W+1)'(1);
            end
          end
        end
        ST_ROUND: begin
          result   <= result_nx;
          overflow <= ovf_nx;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_fp_normalize_round.sv
// tb/tb_fp_normalize_round.sv - self-checking bench for fp_normalize_round

module tb_fp_normalize_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [24:0] mant_in;
  logic [2:0]  grs_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;

  fp_normalize_round dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sign_in  (sign_in),
    .exp_in   (exp_in),
    .mant_in  (mant_in),
    .grs_in   (grs_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          k;
    int          sc;
  } exp_t;

  exp_t q[$];
  exp_t cmp_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Value model: V holds {mant, G, R} as one integer and S is a sticky flag
  // that never moves. The result is found by normalising V, rounding at the
  // 2-bit boundary to nearest even and encoding the IEEE fields.
  function automatic void model(input logic sgn, input int e_in, input logic [24:0] m,
                                input logic [2:0] grs, output logic [31:0] res,
                                output logic ovf, output int k);
    longint v;
    longint keep;
    bit     s;
    bit     g;
    bit     rs;
    int     e;
    v   = longint'({m, grs[2:1]});
    s   = grs[0];
    e   = e_in;
    k   = 0;
    ovf = 1'b0;
    if (v == 0 && !s) begin
      res = {sgn, 31'b0};
      return;
    end
    if (v >= (longint'(1) << 26)) begin
      s = s | v[0];
      v = v >> 1;
      e = e + 1;
      k = 1;
    end else begin
      while (v < (longint'(1) << 25) && e > 1) begin
        v = v << 1;
        e = e - 1;
        k = k + 1;
      end
    end
    keep = v >> 2;
    g    = v[1];
    rs   = v[0] | s;
    if (g && (rs || keep[0])) keep = keep + 1;
    if (keep >= (longint'(1) << 24)) begin
      keep = keep >> 1;
      e    = e + 1;
    end
    if (e >= 255) begin
      res = {sgn, 8'hFF, 23'b0};
      ovf = 1'b1;
    end else begin
      res = {sgn, (keep >= (longint'(1) << 23)) ? e[7:0] : 8'd0, keep[22:0]};
    end
  endfunction

  // Compare process: every cycle an operation is in flight busy must be high;
  // at done the result, overflow, latency and busy are checked against the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          cmp_e = q.pop_front();
          chk("result", result, cmp_e.res);
          chk("overflow", 32'(overflow), 32'(cmp_e.ovf));
          chk("latency", 32'(cyc - cmp_e.sc), 32'(cmp_e.k + 3));
          chk("busy_at_done", 32'(busy), 32'd0);
        end
      end else if (q.size() != 0 && cyc >= q[0].sc) begin
        chk("busy_inflight", 32'(busy), 32'd1);
      end
    end
  end

  task automatic run_op(input logic sgn, input int e, input logic [24:0] m,
                        input logic [2:0] grs, input bit poke);
    exp_t ent;
    model(sgn, e, m, grs, ent.res, ent.ovf, ent.k);
    @(negedge clk);
    sign_in  = sgn;
    exp_in   = 8'(e);
    mant_in  = m;
    grs_in   = grs;
    start    = 1'b1;
    ent.sc   = cyc + 1;
    q.push_back(ent);
    @(negedge clk);
    start    = 1'b0;
    sign_in  = 1'($urandom);
    exp_in   = 8'($urandom);
    mant_in  = 25'($urandom);
    grs_in   = 3'($urandom);
    if (poke) begin
      @(negedge clk);
      sign_in = ~sgn;
      exp_in  = 8'd200;
      mant_in = 25'h1ABCDEF;
      grs_in  = 3'b111;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
    end
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("done_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(negedge clk);
    chk("result_hold", result, ent.res);
  endtask

  task automatic pin(input string name, input logic sgn, input int e, input logic [24:0] m,
                     input logic [2:0] grs, input logic [31:0] want, input int lat);
    logic [31:0] r;
    logic        o;
    int          k;
    model(sgn, e, m, grs, r, o, k);
    chk({name, "_val"}, r, want);
    chk({name, "_lat"}, 32'(k + 3), 32'(lat));
  endtask

  initial begin
    logic [24:0] m;
    int          e;
    int          p;
    logic [2:0]  grs;

    rst = 1'b1; start = 1'b0; sign_in = 1'b0; exp_in = '0; mant_in = '0; grs_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    // Hand-computed expectations that pin the model itself.
    pin("pin_one",   1'b0, 127, 25'h0800000, 3'b000, 32'h3F800000, 3);
    pin("pin_two",   1'b0, 127, 25'h1000000, 3'b000, 32'h40000000, 4);
    pin("pin_lsh23", 1'b0, 127, 25'h0000001, 3'b000, 32'h34000000, 26);
    pin("pin_tie_o", 1'b0, 127, 25'h0800001, 3'b100, 32'h3F800002, 3);
    pin("pin_tie_e", 1'b0, 127, 25'h0800000, 3'b100, 32'h3F800000, 3);
    pin("pin_ovf1",  1'b0, 254, 25'h1FFFFFF, 3'b000, 32'h7F800000, 4);
    pin("pin_ovf2",  1'b1, 254, 25'h0FFFFFF, 3'b110, 32'hFF800000, 3);
    pin("pin_denrm", 1'b0, 3,   25'h0000400, 3'b000, 32'h00001000, 5);
    pin("pin_zero",  1'b1, 127, 25'h0000000, 3'b000, 32'h80000000, 3);

    // The same vectors through the DUT.
    run_op(1'b0, 127, 25'h0800000, 3'b000, 1'b0);
    run_op(1'b0, 127, 25'h1000000, 3'b000, 1'b0);
    run_op(1'b0, 127, 25'h0000001, 3'b000, 1'b0);
    run_op(1'b0, 127, 25'h0800001, 3'b100, 1'b0);
    run_op(1'b0, 127, 25'h0800000, 3'b100, 1'b0);
    run_op(1'b0, 254, 25'h1FFFFFF, 3'b000, 1'b0);
    chk("ovf_flag_direct", 32'(overflow), 32'd1);
    run_op(1'b1, 254, 25'h0FFFFFF, 3'b110, 1'b0);
    run_op(1'b0, 3,   25'h0000400, 3'b000, 1'b0);
    run_op(1'b1, 127, 25'h0000000, 3'b000, 1'b0);
    run_op(1'b0, 1,   25'h07FFFFF, 3'b110, 1'b0);
    chk("denorm_to_norm", result, 32'h00800000);

    // start while busy must be ignored.
    run_op(1'b0, 100, 25'h0000010, 3'b010, 1'b1);

    // Reset in NORM aborts with no done pulse.
    @(negedge clk);
    sign_in = 1'b0; exp_in = 8'd127; mant_in = 25'h0000001; grs_in = 3'b000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    // Randomised operations.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 7))
        0, 1:    e = int'($urandom_range(1, 4));
        2:       e = int'($urandom_range(250, 254));
        default: e = int'($urandom_range(1, 254));
      endcase
      p   = int'($urandom_range(0, 24));
      m   = (25'($urandom) & ((25'd1 << p) - 25'd1)) | (25'd1 << p);
      grs = 3'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        m   = '0;
        grs = '0;
      end
      run_op(1'($urandom), e, m, grs, 1'($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
